if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a DEPTH-entry prefetch FIFO. It replaces the single-register fetch stage. It issues classic strobe/ack requests to instruction memory, buffers {pc, instr} pairs, and presents them to decode with a stall-based handshake. It also takes branch and jalr redirects from execute, flushes stale instructions, and discards any in-flight response from the wrong path.

---
 rtl/if_prefetch_if.sv | 38 +++
 rtl/if_prefetch.sv | 130 +++++++++++++
 tb/tb_if_prefetch.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// Fetch-stage bundle: instruction-memory strobe/ack bus, decode handshake,
// and redirect inputs from execute. "master" is the fetch stage itself.
interface if_prefetch_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Instruction memory side
  logic            o_Imem_stb;
  logic [XLEN-1:0] o_Iaddr;
  logic [XLEN-1:0] i_Inst;
  logic            i_Imem_ack;

  // Decode side
  logic            o_Valid;
  logic [XLEN-1:0] o_PcD;
  logic [XLEN-1:0] o_InstrD;
  logic            i_Stall;
  logic [LW-1:0]   o_Level;

  // Redirect from execute
  logic            i_Boj;
  logic            i_Jalr;
  logic [XLEN-1:0] i_PcE;
  logic [XLEN-1:0] i_Imm;
  logic [XLEN-1:0] i_Result;

  modport master (
    output o_Imem_stb, o_Iaddr, o_Valid, o_PcD, o_InstrD, o_Level,
    input  i_Inst, i_Imem_ack, i_Stall, i_Boj, i_Jalr, i_PcE, i_Imm, i_Result
  );

  modport slave (
    input  o_Imem_stb, o_Iaddr, o_Valid, o_PcD, o_InstrD, o_Level,
    output i_Inst, i_Imem_ack, i_Stall, i_Boj, i_Jalr, i_PcE, i_Imm, i_Result
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch FIFO. Keeps at most one
// strobe/ack request in flight, always with a FIFO slot reserved for its
// response, and flushes / discards wrong-path work on a branch or jalr.
module if_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  if_prefetch_if.master bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              LW       = AW + 1;
  localparam logic [LW-1:0]   FULL     = LW'(DEPTH);
  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] ALIGN_M  = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_iaddr, r_fetch_pc;
  logic            r_discard;
  logic [LW-1:0]   r_level;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];

  logic [XLEN-1:0] w_br_sum, w_target, w_base_pc;
  logic [XLEN-1:0] w_iaddr_nxt, w_fetch_pc_nxt;
  logic [LW-1:0]   w_level_nxt;
  logic            w_redirect, w_ack, w_valid, w_push, w_pop, w_issue, w_discard_nxt;

  // Redirect target: jalr wins over branch/jal; low two bits always cleared.
  assign w_br_sum   = bus.i_PcE + bus.i_Imm;
  assign w_target   = (bus.i_Jalr ? bus.i_Result : w_br_sum) & ALIGN_M;
  assign w_redirect = bus.i_Boj | bus.i_Jalr;
  // A redirect overrides the fetch PC source on the same edge.
  assign w_base_pc  = w_redirect ? w_target : r_fetch_pc;

  // Ack only counts while strobing; a redirect flushes, so neither push nor pop.
  assign w_ack   = (r_state == S_REQ) && bus.i_Imem_ack;
  assign w_valid = (r_level != '0);
  assign w_push  = w_ack && !r_discard && !w_redirect;
  assign w_pop   = w_valid && !bus.i_Stall && !w_redirect;

  // Occupancy after this edge's push/pop; drives the issue decision.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_level_nxt = r_level;
    if (w_redirect)          w_level_nxt = '0;
    else if (w_push && !w_pop) w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
  end

  // FSM next state and issue decision (new request only into a free slot).
  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_discard_nxt = r_discard;
    case (r_state)
      S_IDLE: begin
        if (w_level_nxt < FULL) begin
          w_issue     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack) begin
          w_discard_nxt = 1'b0;
          if (w_level_nxt < FULL) w_issue = 1'b1;
          else                    w_state_nxt = S_IDLE;
        end else if (w_redirect) begin
          // Old request still open: its response belongs to the wrong path.
          w_discard_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_iaddr_nxt    = w_issue ? w_base_pc : r_iaddr;
    w_fetch_pc_nxt = w_issue ? w_base_pc + XLEN'(4) : w_base_pc;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request address, fetch PC, discard flag and FIFO bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iaddr    <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
      r_level    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_iaddr    <= w_iaddr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_discard  <= w_discard_nxt;
      r_level    <= w_level_nxt;
      if (w_redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage write of {pc, instr}.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; empty entries are never visible because outputs are masked by o_Valid.
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_iaddr;
      r_instr_mem[r_wr_ptr] <= bus.i_Inst;
    end
  end

  assign bus.o_Imem_stb = (r_state == S_REQ);
  assign bus.o_Iaddr    = r_iaddr;
  assign bus.o_Valid    = w_valid;
  assign bus.o_Level    = r_level;
  assign bus.o_PcD      = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign bus.o_InstrD   = w_valid ? r_instr_mem[r_rd_ptr] : NOP;
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, backpressure, branch, jalr with
// wait states, simultaneous redirect+ack, PC wrap and mid-request reset.
module tb_if_prefetch;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] CINST = 32'h0010_6293;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   const_mode = 1'b1;
  int   checks = 0;
  int   errors = 0;

  if_prefetch_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory returns either a fixed word or an address-tagged word.
  assign bus.i_Inst = const_mode ? CINST : {8'hA5, bus.o_Iaddr[23:0]};

  function automatic logic [31:0] tag(input logic [31:0] pc);
    return {8'hA5, pc[23:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_Imem_ack = 1'b0;
    bus.i_Stall    = 1'b0;
    bus.i_Boj      = 1'b0;
    bus.i_Jalr     = 1'b0;
    bus.i_PcE      = '0;
    bus.i_Imm      = '0;
    bus.i_Result   = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    checks++; if (bus.o_Imem_stb !== 1'b0) begin errors++; $display("FAIL reset stb: got %b want 0", bus.o_Imem_stb); end
    checks++; if (bus.o_Iaddr !== 32'h0) begin errors++; $display("FAIL reset iaddr: got %h want 0", bus.o_Iaddr); end
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", bus.o_Valid); end
    checks++; if (bus.o_PcD !== 32'h0) begin errors++; $display("FAIL reset pcd: got %h want 0", bus.o_PcD); end
    checks++; if (bus.o_InstrD !== NOP) begin errors++; $display("FAIL reset instr: got %h want %h", bus.o_InstrD, NOP); end
    checks++; if (bus.o_Level !== 3'd0) begin errors++; $display("FAIL reset level: got %0d want 0", bus.o_Level); end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] e;
    const_mode = 1'b1;
    apply_reset();
    bus.i_Imem_ack = 1'b1;
    step();
    checks++; if (bus.o_Imem_stb !== 1'b1) begin errors++; $display("FAIL stream first stb: got %b want 1", bus.o_Imem_stb); end
    checks++; if (bus.o_Iaddr !== 32'h0) begin errors++; $display("FAIL stream first iaddr: got %h want 0", bus.o_Iaddr); end
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL stream first valid: got %b want 0", bus.o_Valid); end
    for (int k = 1; k <= 5; k++) begin
      step();
      e = 32'(4 * k);
      checks++; if (bus.o_Iaddr !== e) begin errors++; $display("FAIL stream iaddr[%0d]: got %h want %h", k, bus.o_Iaddr, e); end
      checks++; if (bus.o_Valid !== 1'b1) begin errors++; $display("FAIL stream valid[%0d]: got %b want 1", k, bus.o_Valid); end
      checks++; if (bus.o_PcD !== e - 32'h4) begin errors++; $display("FAIL stream pcd[%0d]: got %h want %h", k, bus.o_PcD, e - 32'h4); end
      checks++; if (bus.o_InstrD !== CINST) begin errors++; $display("FAIL stream instr[%0d]: got %h want %h", k, bus.o_InstrD, CINST); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    const_mode = 1'b0;
    apply_reset();
    bus.i_Imem_ack = 1'b1;
    bus.i_Stall    = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (bus.o_Level !== 3'(k)) begin errors++; $display("FAIL bp level[%0d]: got %0d want %0d", k, bus.o_Level, k); end
      checks++; if (bus.o_PcD !== 32'h0) begin errors++; $display("FAIL bp held pcd[%0d]: got %h want 0", k, bus.o_PcD); end
    end
    checks++; if (bus.o_Imem_stb !== 1'b0) begin errors++; $display("FAIL bp full stb: got %b want 0", bus.o_Imem_stb); end
    step();
    step();
    checks++; if (bus.o_Imem_stb !== 1'b0) begin errors++; $display("FAIL bp still stb: got %b want 0", bus.o_Imem_stb); end
    checks++; if (bus.o_Level !== 3'd4) begin errors++; $display("FAIL bp still level: got %0d want 4", bus.o_Level); end
    checks++; if (bus.o_InstrD !== tag(32'h0)) begin errors++; $display("FAIL bp held instr: got %h want %h", bus.o_InstrD, tag(32'h0)); end
    bus.i_Stall = 1'b0;
    step();
    checks++; if (bus.o_PcD !== 32'h4) begin errors++; $display("FAIL bp release pcd: got %h want 4", bus.o_PcD); end
    checks++; if (bus.o_Level !== 3'd3) begin errors++; $display("FAIL bp release level: got %0d want 3", bus.o_Level); end
    checks++; if (bus.o_Imem_stb !== 1'b1) begin errors++; $display("FAIL bp resume stb: got %b want 1", bus.o_Imem_stb); end
    checks++; if (bus.o_Iaddr !== 32'h10) begin errors++; $display("FAIL bp resume iaddr: got %h want 10", bus.o_Iaddr); end
    for (int k = 2; k <= 4; k++) begin
      step();
      e = 32'(4 * k);
      checks++; if (bus.o_PcD !== e) begin errors++; $display("FAIL bp drain pcd[%0d]: got %h want %h", k, bus.o_PcD, e); end
      checks++; if (bus.o_InstrD !== tag(e)) begin errors++; $display("FAIL bp drain instr[%0d]: got %h want %h", k, bus.o_InstrD, tag(e)); end
    end
  endtask

  task automatic test_branch();
    const_mode = 1'b0;
    apply_reset();
    bus.i_Imem_ack = 1'b1;
    repeat (4) step();
    checks++; if (bus.o_PcD !== 32'h8) begin errors++; $display("FAIL br pre pcd: got %h want 8", bus.o_PcD); end
    bus.i_Boj = 1'b1;
    bus.i_PcE = 32'h8;
    bus.i_Imm = 32'hC;
    step();
    bus.i_Boj = 1'b0;
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL br flush valid: got %b want 0", bus.o_Valid); end
    checks++; if (bus.o_Level !== 3'd0) begin errors++; $display("FAIL br flush level: got %0d want 0", bus.o_Level); end
    checks++; if (bus.o_Iaddr !== 32'h14) begin errors++; $display("FAIL br target iaddr: got %h want 14", bus.o_Iaddr); end
    step();
    checks++; if (bus.o_PcD !== 32'h14) begin errors++; $display("FAIL br target pcd: got %h want 14", bus.o_PcD); end
    checks++; if (bus.o_InstrD !== tag(32'h14)) begin errors++; $display("FAIL br target instr: got %h want %h", bus.o_InstrD, tag(32'h14)); end
    step();
    checks++; if (bus.o_PcD !== 32'h18) begin errors++; $display("FAIL br next pcd: got %h want 18", bus.o_PcD); end
  endtask

  task automatic test_jalr_wait();
    const_mode = 1'b0;
    apply_reset();
    step();
    checks++; if (bus.o_Imem_stb !== 1'b1) begin errors++; $display("FAIL jw issue stb: got %b want 1", bus.o_Imem_stb); end
    step();
    bus.i_Jalr   = 1'b1;
    bus.i_Result = 32'hF;
    step();
    bus.i_Jalr = 1'b0;
    checks++; if (bus.o_Iaddr !== 32'h0) begin errors++; $display("FAIL jw held iaddr: got %h want 0", bus.o_Iaddr); end
    checks++; if (bus.o_Imem_stb !== 1'b1) begin errors++; $display("FAIL jw held stb: got %b want 1", bus.o_Imem_stb); end
    step();
    checks++; if (bus.o_Iaddr !== 32'h0) begin errors++; $display("FAIL jw held2 iaddr: got %h want 0", bus.o_Iaddr); end
    bus.i_Imem_ack = 1'b1;
    step();
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL jw discard valid: got %b want 0", bus.o_Valid); end
    checks++; if (bus.o_Iaddr !== 32'hC) begin errors++; $display("FAIL jw target iaddr: got %h want c", bus.o_Iaddr); end
    step();
    checks++; if (bus.o_PcD !== 32'hC) begin errors++; $display("FAIL jw target pcd: got %h want c", bus.o_PcD); end
    checks++; if (bus.o_InstrD !== tag(32'hC)) begin errors++; $display("FAIL jw target instr: got %h want %h", bus.o_InstrD, tag(32'hC)); end
    checks++; if (bus.o_Iaddr !== 32'h10) begin errors++; $display("FAIL jw next iaddr: got %h want 10", bus.o_Iaddr); end
  endtask

  task automatic test_simultaneous();
    const_mode = 1'b0;
    apply_reset();
    bus.i_Imem_ack = 1'b1;
    step();
    step();
    bus.i_Boj    = 1'b1;
    bus.i_PcE    = 32'h100;
    bus.i_Imm    = 32'h20;
    bus.i_Jalr   = 1'b1;
    bus.i_Result = 32'h41;
    step();
    bus.i_Boj  = 1'b0;
    bus.i_Jalr = 1'b0;
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL sim flush valid: got %b want 0", bus.o_Valid); end
    checks++; if (bus.o_Iaddr !== 32'h40) begin errors++; $display("FAIL sim target iaddr: got %h want 40", bus.o_Iaddr); end
    step();
    checks++; if (bus.o_PcD !== 32'h40) begin errors++; $display("FAIL sim target pcd: got %h want 40", bus.o_PcD); end
    checks++; if (bus.o_Valid !== 1'b1) begin errors++; $display("FAIL sim target valid: got %b want 1", bus.o_Valid); end
    step();
    checks++; if (bus.o_PcD !== 32'h44) begin errors++; $display("FAIL sim next pcd: got %h want 44", bus.o_PcD); end
    checks++; if (bus.o_Iaddr !== 32'h48) begin errors++; $display("FAIL sim next iaddr: got %h want 48", bus.o_Iaddr); end
  endtask

  task automatic test_wrap();
    const_mode = 1'b0;
    apply_reset();
    bus.i_Imem_ack = 1'b1;
    step();
    step();
    bus.i_Jalr   = 1'b1;
    bus.i_Result = 32'hFFFF_FFFE;
    step();
    bus.i_Jalr = 1'b0;
    checks++; if (bus.o_Iaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap top iaddr: got %h want fffffffc", bus.o_Iaddr); end
    step();
    checks++; if (bus.o_PcD !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap top pcd: got %h want fffffffc", bus.o_PcD); end
    checks++; if (bus.o_Iaddr !== 32'h0) begin errors++; $display("FAIL wrap zero iaddr: got %h want 0", bus.o_Iaddr); end
    step();
    checks++; if (bus.o_PcD !== 32'h0 || bus.o_Valid !== 1'b1) begin errors++; $display("FAIL wrap zero pcd: got %h/%b want 0/1", bus.o_PcD, bus.o_Valid); end
    checks++; if (bus.o_InstrD !== tag(32'h0)) begin errors++; $display("FAIL wrap zero instr: got %h want %h", bus.o_InstrD, tag(32'h0)); end
  endtask

  task automatic test_reset_mid();
    const_mode = 1'b0;
    apply_reset();
    bus.i_Imem_ack = 1'b1;
    bus.i_Stall    = 1'b1;
    repeat (3) step();
    checks++; if (bus.o_Level !== 3'd2) begin errors++; $display("FAIL rm pre level: got %0d want 2", bus.o_Level); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_Imem_stb !== 1'b0) begin errors++; $display("FAIL rm async stb: got %b want 0", bus.o_Imem_stb); end
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL rm async valid: got %b want 0", bus.o_Valid); end
    checks++; if (bus.o_InstrD !== NOP) begin errors++; $display("FAIL rm async instr: got %h want %h", bus.o_InstrD, NOP); end
    checks++; if (bus.o_Iaddr !== 32'h0) begin errors++; $display("FAIL rm async iaddr: got %h want 0", bus.o_Iaddr); end
    step();
    #2 rst = 1'b0;
    bus.i_Stall = 1'b0;
    step();
    checks++; if (bus.o_Imem_stb !== 1'b1 || bus.o_Iaddr !== 32'h0) begin errors++; $display("FAIL rm restart: got stb %b iaddr %h want 1/0", bus.o_Imem_stb, bus.o_Iaddr); end
    step();
    checks++; if (bus.o_PcD !== 32'h0 || bus.o_Valid !== 1'b1) begin errors++; $display("FAIL rm first pcd: got %h/%b want 0/1", bus.o_PcD, bus.o_Valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_branch();
    test_jalr_wait();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
